// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types and constants for the data-memory arbiter
// Contents: arbiter state enum, default address/data widths, port index constants.
package dmem_arb_pkg;

    localparam int DMEM_AW = 8;
    localparam int DMEM_DW = 8;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

endpackage

// File: rtl/dmem_arb_if.sv
// rtl/dmem_arb_if.sv - bundle of requester and memory-side signals for dmem_arb
// Signals:
//   req0/req1, we0/we1, addr0/addr1, wd0/wd1 : requester access (to arbiter)
//   gnt0/gnt1, rd0/rd1                       : grant and load data (from arbiter)
//   mem_addr, mem_we, mem_wd                 : memory controls (from arbiter)
//   mem_rd                                   : memory combinational read data (to arbiter)
//   busy                                     : arbiter not idle
// Modports: slave = arbiter view, master = requesters + memory view.
interface dmem_arb_if
    import dmem_arb_pkg::*;
#(
    parameter int AW = DMEM_AW,
    parameter int DW = DMEM_DW
);
    logic          req0;
    logic          req1;
    logic          we0;
    logic          we1;
    logic [AW-1:0] addr0;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wd0;
    logic [DW-1:0] wd1;
    logic          gnt0;
    logic          gnt1;
    logic [DW-1:0] rd0;
    logic [DW-1:0] rd1;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wd;
    logic [DW-1:0] mem_rd;
    logic          busy;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wd0, wd1, mem_rd,
        output gnt0, gnt1, rd0, rd1, mem_addr, mem_we, mem_wd, busy
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wd0, wd1, mem_rd,
        input  gnt0, gnt1, rd0, rd1, mem_addr, mem_we, mem_wd, busy
    );

endinterface

// File: rtl/dmem_arb_sel.sv
// rtl/dmem_arb_sel.sv - winner pick for a grant taken from IDLE
// Ports:
//   req0, req1 : in  pending requests
//   last       : in  port served most recently
//   valid      : out at least one request pending
//   pick       : out winning port index
// Build option DMEM_ARB_RR_EN: ties go to the port not served last;
// otherwise port 0 wins every tie.
module dmem_arb_sel
    import dmem_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic valid,
    output logic pick
);

`ifdef DMEM_ARB_RR_EN
    always_comb begin
        valid = req0 | req1;
        if (req0 && req1) begin
            pick = ~last;
        end else begin
            pick = req1 ? PORT1 : PORT0;
        end
    end
`else
    // Fixed priority has no use for the history pointer.
    logic unused_last;
    assign unused_last = last;

    always_comb begin
        valid = req0 | req1;
        if (req0) begin
            pick = PORT0;
        end else begin
            pick = req1 ? PORT1 : PORT0;
        end
    end
`endif

endmodule

// File: rtl/dmem_arb.sv
// rtl/dmem_arb.sv - two-port arbiter for the single data-memory port
// Ports:
//   ck   : in  clock, rising edge
//   res  : in  asynchronous active-high reset
//   bus  : dmem_arb_if.slave - requester req/we/addr/wd in, gnt/rd out,
//          memory mem_addr/mem_we/mem_wd out, mem_rd in, busy out
// Parameters: AW, DW widths; MAX_HOLD max consecutive grant cycles while the
// other port waits (>=1).
// Build option DMEM_ARB_RR_EN: round-robin tie break from IDLE (see dmem_arb_sel).
module dmem_arb
    import dmem_arb_pkg::*;
#(
    parameter int AW       = DMEM_AW,
    parameter int DW       = DMEM_DW,
    parameter int MAX_HOLD = 4
)
(
    input  logic       ck,
    input  logic       res,
    dmem_arb_if.slave  bus
);

    localparam int             HW        = $clog2(MAX_HOLD) + 1;
    localparam logic [HW-1:0]  HOLD_LAST = HW'(MAX_HOLD - 1);

    arb_state_t    state;
    logic [HW-1:0] hold;
    logic          last;

    logic          pick_valid;
    logic          pick;

    logic          own_req;
    logic          oth_req;
    arb_state_t    oth_state;
    logic          oth_port;

    logic [AW-1:0] addr_mux;
    logic [DW-1:0] wd_mux;
    logic          we_mux;

    dmem_arb_sel u_sel (
        .req0  (bus.req0),
        .req1  (bus.req1),
        .last  (last),
        .valid (pick_valid),
        .pick  (pick)
    );

    // Owner-relative view so OWN0 and OWN1 share one set of transition rules.
    always_comb begin
        own_req   = (state == OWN1) ? bus.req1 : bus.req0;
        oth_req   = (state == OWN1) ? bus.req0 : bus.req1;
        oth_state = (state == OWN1) ? OWN0 : OWN1;
        oth_port  = (state == OWN1) ? PORT0 : PORT1;
    end

    always_ff @(posedge ck or posedge res) begin
        if (res) begin
            state <= IDLE;
            hold  <= '0;
            last  <= PORT1;
        end else begin
            case (state)
                IDLE: begin
                    hold <= '0;
                    if (pick_valid) begin
                        state <= pick ? OWN1 : OWN0;
                        last  <= pick;
                    end
                end
                OWN0, OWN1: begin
                    if (!own_req) begin
                        hold <= '0;
                        if (oth_req) begin
                            state <= oth_state;
                            last  <= oth_port;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (!oth_req) begin
                        hold <= '0;
                    end else if (hold >= HOLD_LAST) begin
                        // Tenure used up while the other side waits: hand over.
                        hold  <= '0;
                        state <= oth_state;
                        last  <= oth_port;
                    end else begin
                        hold <= hold + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    hold  <= '0;
                end
            endcase
        end
    end

    always_comb begin
        addr_mux = '0;
        wd_mux   = '0;
        we_mux   = 1'b0;
        case (state)
            OWN0: begin
                addr_mux = bus.addr0;
                wd_mux   = bus.wd0;
                we_mux   = bus.req0 & bus.we0;
            end
            OWN1: begin
                addr_mux = bus.addr1;
                wd_mux   = bus.wd1;
                we_mux   = bus.req1 & bus.we1;
            end
            default: begin
                addr_mux = '0;
                wd_mux   = '0;
                we_mux   = 1'b0;
            end
        endcase
    end

    assign bus.gnt0     = (state == OWN0);
    assign bus.gnt1     = (state == OWN1);
    assign bus.busy     = (state != IDLE);
    assign bus.mem_addr = addr_mux;
    assign bus.mem_wd   = wd_mux;
    // Gate with res so a store in flight when reset rises cannot commit.
    assign bus.mem_we   = we_mux & ~res;
    assign bus.rd0      = (state == OWN0) ? bus.mem_rd : '0;
    assign bus.rd1      = (state == OWN1) ? bus.mem_rd : '0;

endmodule

// File: tb/tb_dmem_arb.sv
// tb/tb_dmem_arb.sv - self-checking bench for dmem_arb with a 256x8 memory model
module tb_dmem_arb;

    localparam int MAX_HOLD = 4;

    logic ck  = 1'b0;
    logic res = 1'b1;

    int total = 0;
    int bad   = 0;

    dmem_arb_if #(.AW(8), .DW(8)) bus ();

    dmem_arb #(.AW(8), .DW(8), .MAX_HOLD(MAX_HOLD)) dut (
        .ck  (ck),
        .res (res),
        .bus (bus)
    );

    always #5 ck = ~ck;

    // Memory device: sync write, async read.
    logic [7:0] mem [256];
    bit         mem_ready;
    assign bus.mem_rd = mem[bus.mem_addr];

    always @(posedge ck) begin
        if (!mem_ready) begin
            for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hA5;
            mem_ready = 1'b1;
        end else if (bus.mem_we) begin
            mem[bus.mem_addr] = bus.mem_wd;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: who owns the memory, how long it has been contended,
    // who was served last, and what the memory should hold.
    int         owner  = -1;
    int         streak = 0;
    int         served = 1;
    logic [7:0] refmem [256];
    bit         ref_ready;

    always @(posedge ck or posedge res) begin
        bit         r [2];
        bit         w [2];
        logic [7:0] a [2];
        logic [7:0] d [2];
        int         nxt;
        if (res) begin
            if (!ref_ready) begin
                for (int i = 0; i < 256; i++) refmem[i] = 8'(i) ^ 8'hA5;
                ref_ready = 1'b1;
            end
            owner  = -1;
            streak = 0;
            served = 1;
        end else begin
            r[0] = bus.req0; r[1] = bus.req1;
            w[0] = bus.we0;  w[1] = bus.we1;
            a[0] = bus.addr0; a[1] = bus.addr1;
            d[0] = bus.wd0;  d[1] = bus.wd1;
            if (owner < 0) begin
                streak = 0;
                if (r[0] && r[1]) begin
`ifdef DMEM_ARB_RR_EN
                    nxt = 1 - served;
`else
                    nxt = 0;
`endif
                end else if (r[0]) nxt = 0;
                else if (r[1])     nxt = 1;
                else               nxt = -1;
            end else begin
                if (r[owner] && w[owner]) refmem[a[owner]] = d[owner];
                if (!r[owner]) begin
                    streak = 0;
                    nxt = r[1-owner] ? 1 - owner : -1;
                end else if (!r[1-owner]) begin
                    streak = 0;
                    nxt = owner;
                end else begin
                    streak++;
                    if (streak == MAX_HOLD) begin
                        streak = 0;
                        nxt = 1 - owner;
                    end else begin
                        nxt = owner;
                    end
                end
            end
            if (nxt >= 0 && nxt != owner) served = nxt;
            owner = nxt;
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge ck) begin
        logic [7:0] ea;
        logic [7:0] ew;
        logic       ewe;
        ea  = 8'h00;
        ew  = 8'h00;
        ewe = 1'b0;
        if (owner == 0) begin
            ea = bus.addr0; ew = bus.wd0; ewe = bus.req0 & bus.we0;
        end else if (owner == 1) begin
            ea = bus.addr1; ew = bus.wd1; ewe = bus.req1 & bus.we1;
        end
        if (res) ewe = 1'b0;
        chk("gnt0",     32'(bus.gnt0),     32'(owner == 0));
        chk("gnt1",     32'(bus.gnt1),     32'(owner == 1));
        chk("busy",     32'(bus.busy),     32'(owner >= 0));
        chk("mem_addr", 32'(bus.mem_addr), 32'(ea));
        chk("mem_wd",   32'(bus.mem_wd),   32'(ew));
        chk("mem_we",   32'(bus.mem_we),   32'(ewe));
        chk("rd0",      32'(bus.rd0),      (owner == 0) ? 32'(refmem[ea]) : 32'd0);
        chk("rd1",      32'(bus.rd1),      (owner == 1) ? 32'(refmem[ea]) : 32'd0);
        chk("gnt_excl", 32'(bus.gnt0 & bus.gnt1), 32'd0);
    end

    task automatic cyc();
        @(posedge ck);
        #1;
    endtask

    task automatic peek();
        #2;
    endtask

    task automatic pulse_reset();
        res = 1'b1;
        cyc();
        res = 1'b0;
        cyc();
    endtask

    initial begin
        logic [1:0] seq     [10];
        logic [1:0] seq_exp [10];
        logic [1:0] first_g;
        logic [1:0] second_g;
        logic [1:0] second_exp;

        bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0;
        bus.addr0 = 0; bus.addr1 = 0; bus.wd0 = 0; bus.wd1 = 0;

        // Reset state
        repeat (3) cyc();
        peek();
        chk("rst_gnt0", 32'(bus.gnt0), 0);
        chk("rst_gnt1", 32'(bus.gnt1), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_we",   32'(bus.mem_we), 0);
        chk("rst_rd0",  32'(bus.rd0), 0);
        res = 1'b0;
        cyc();

        // Store then load on port 0
        bus.req0 = 1; bus.we0 = 1; bus.addr0 = 8'h10; bus.wd0 = 8'h5A;
        peek();
        chk("t1_idle_gnt0", 32'(bus.gnt0), 0);
        cyc();
        peek();
        chk("t1_gnt0",  32'(bus.gnt0), 1);
        chk("t1_we",    32'(bus.mem_we), 1);
        chk("t1_addr",  32'(bus.mem_addr), 32'h10);
        cyc();
        bus.we0 = 0;
        peek();
        chk("t1_rd0",   32'(bus.rd0), 32'h5A);
        chk("t1_ld_we", 32'(bus.mem_we), 0);
        cyc();
        bus.req0 = 0;
        peek();
        chk("t1_tail_gnt0", 32'(bus.gnt0), 1);
        chk("t1_tail_we",   32'(bus.mem_we), 0);
        cyc();
        peek();
        chk("t1_end_busy", 32'(bus.busy), 0);

        // Both ports held: 4/4 alternation with no gap
        pulse_reset();
        bus.addr0 = 8'h10; bus.addr1 = 8'h20; bus.we0 = 0; bus.we1 = 0;
        bus.req0 = 1; bus.req1 = 1;
        seq_exp = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b01,
                    2'b10, 2'b10, 2'b10, 2'b10, 2'b01};
        for (int i = 0; i < 10; i++) begin
            peek();
            seq[i] = {bus.gnt1, bus.gnt0};
            cyc();
        end
        for (int i = 0; i < 10; i++) chk($sformatf("t2_seq%0d", i), 32'(seq[i]), 32'(seq_exp[i]));
        bus.req0 = 0; bus.req1 = 0;
        cyc();
        cyc();

        // Simultaneous requests from IDLE, twice
        pulse_reset();
        bus.req0 = 1; bus.req1 = 1;
        cyc();
        peek();
        first_g = {bus.gnt1, bus.gnt0};
        bus.req0 = 0; bus.req1 = 0;
        cyc();
        peek();
        chk("t3_gap_busy", 32'(bus.busy), 0);
        bus.req0 = 1; bus.req1 = 1;
        cyc();
        peek();
        second_g = {bus.gnt1, bus.gnt0};
        bus.req0 = 0; bus.req1 = 0;
`ifdef DMEM_ARB_RR_EN
        second_exp = 2'b10;
`else
        second_exp = 2'b01;
`endif
        chk("t3_first",  32'(first_g), 32'(2'b01));
        chk("t3_second", 32'(second_g), 32'(second_exp));
        cyc();
        cyc();

        // Port 1 store, drop while port 0 waits
        bus.req1 = 1; bus.we1 = 1; bus.addr1 = 8'h20; bus.wd1 = 8'h33;
        cyc();
        bus.req0 = 1; bus.we0 = 0; bus.addr0 = 8'h10;
        peek();
        chk("t4_gnt1", 32'(bus.gnt1), 1);
        chk("t4_we",   32'(bus.mem_we), 1);
        cyc();
        bus.req1 = 0;
        peek();
        chk("t4_drop_gnt1", 32'(bus.gnt1), 1);
        chk("t4_drop_we",   32'(bus.mem_we), 0);
        cyc();
        peek();
        chk("t4_hand_gnt1", 32'(bus.gnt1), 0);
        chk("t4_hand_gnt0", 32'(bus.gnt0), 1);
        chk("t4_rd0",       32'(bus.rd0), 32'h5A);
        chk("t4_mem20",     32'(mem[8'h20]), 32'h33);
        bus.req0 = 0; bus.we1 = 0;
        cyc();
        cyc();

        // Reset in the middle of a store
        bus.req1 = 1; bus.we1 = 1; bus.addr1 = 8'h30; bus.wd1 = 8'hEE;
        cyc();
        peek();
        chk("t5_gnt1", 32'(bus.gnt1), 1);
        chk("t5_we",   32'(bus.mem_we), 1);
        res = 1'b1;
        #1;
        chk("t5_rst_gnt1", 32'(bus.gnt1), 0);
        chk("t5_rst_we",   32'(bus.mem_we), 0);
        chk("t5_rst_busy", 32'(bus.busy), 0);
        cyc();
        chk("t5_mem30", 32'(mem[8'h30]), 32'h95);
        res = 1'b0; bus.req1 = 0; bus.we1 = 0;
        cyc();

        // Idle with stale addresses on the inputs
        for (int i = 0; i < 5; i++) begin
            peek();
            chk("t6_we",   32'(bus.mem_we), 0);
            chk("t6_addr", 32'(bus.mem_addr), 0);
            chk("t6_rd",   32'(bus.rd0 | bus.rd1), 0);
            chk("t6_busy", 32'(bus.busy), 0);
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule

// File: doc/dmem_arb.md
# dmem_arb

Two-port arbiter that shares the single data-memory port between the CPU load/store stage (port 0) and an auxiliary requester such as DMA or debug loader (port 1). It grants the memory to one requester at a time using a req/gnt handshake and bounds grant tenure so neither side starves. It steers address, write data and write enable to the memory and returns the memory's combinational read data to the owning port. It sits between the execute stage / aux master and the 256×8 data memory (sync write, async read).

## Interface
- AW, 8, address width (memory depth 2^AW)
- DW, 8, data width
- MAX_HOLD, 4, max consecutive granted cycles while the other port is waiting (≥1)

- ck  in  1  clock, rising edge
- res  in  1  asynchronous, active-high reset
- req0 / req1  in  1  access request, held until gnt seen and access done
- we0 / we1  in  1  1 = store, 0 = load; qualified by reqN & gntN
- addr0 / addr1  in  AW  access address
- wd0 / wd1  in  DW  store data
- gnt0 / gnt1  out  1  registered grant; at most one high
- rd0 / rd1  out  DW  load data; valid in any cycle gntN=1, else 0
- mem_addr  out  AW  to memory address
- mem_we  out  1  to memory write enable
- mem_wd  out  DW  to memory write data
- mem_rd  in  DW  from memory, combinational read of mem_addr
- busy  out  1  state ≠ IDLE

## Operation
- States: IDLE, OWN0, OWN1 (registered). gnt0 = (state==OWN0), gnt1 = (state==OWN1).
- IDLE: no req → IDLE; one req → OWN of that port; both → pick per Configuration.
- OWNx, reqx=1, other idle → stay; hold counter cleared.
- OWNx, reqx=1, other requesting → stay and increment hold; when hold reaches MAX_HOLD−1 in that cycle, next state OWN(other), hold cleared.
- OWNx, reqx=0 → OWN(other) if other requests, else IDLE.
- Mux: owner's addr/wd drive mem_addr/mem_wd; in IDLE mem_addr=0, mem_wd=0.
- mem_we = gntx & reqx & wex of owner; never asserted in IDLE or while res=1.
- rdx = mem_rd when gntx=1, else 0.
- Hold counter width ceil(log2(MAX_HOLD))+1, saturates, never wraps.

## Timing
- Reset values: state IDLE, gnt0=gnt1=0, mem_we=0, mem_addr=0, mem_wd=0, rd0=rd1=0, busy=0, hold=0, RR pointer=last-served port 1.
- Grant latency: req rising in cycle n → gnt high in cycle n+1 (from IDLE, uncontended).
- Access: one load or store per granted cycle; store commits at the rising edge ending a cycle with gnt&req&we; load data valid same cycle as gnt.
- Handoff: zero idle cycles; gnt0 falls and gnt1 rises on the same edge.
- A requester that drops req keeps gnt one more cycle; mem_we=0 in that cycle since req=0.
- Reset asserted mid-access: all state cleared immediately; the in-flight store is not committed.

## Configuration
- DMEM_ARB_RR_EN defined: simultaneous requests from IDLE go to the port not served last (pointer updated on every grant entry); first contended grant after reset goes to port 0.
- Not defined: fixed priority, port 0 wins all IDLE ties. MAX_HOLD bounding applies in both modes.

## Structure
- Package dmem_arb_pkg: state enum (IDLE/OWN0/OWN1), AW/DW defaults, port index constants.
- Sub-module dmem_arb_sel: combinational winner pick from req0, req1, last-served pointer; contains the RR/fixed logic under DMEM_ARB_RR_EN.

## Test plan
- Reset then req0=1, we0=1, addr0=8'h10, wd0=8'h5A for 2 cycles, then load from 8'h10 → gnt0 high from cycle 1, mem_we pulses, rd0=8'h5A.
- req0 and req1 both held 10 cycles, MAX_HOLD=4 → grants alternate 4/4 with no gap; gnt0 and gnt1 never both high.
- Simultaneous first req from IDLE, twice separated by IDLE → fixed mode: port 0 both times; RR mode: port 0 then port 1.
- OWN1 store in progress, req1 drops while req0 waiting → gnt1 low and gnt0 high on the same edge; no store in the drop cycle.
- Assert res mid-store with we1=1 → gnt1, mem_we, busy go 0 immediately; target address keeps old value.
- Idle with no requests → mem_we=0, mem_addr=0, rd0=rd1=0, busy=0 for all cycles.
